rc4_encryptor: RTL

//  Single-core RC4 writer: runs init/KSA/PRGA for one key, reads a plaintext message, writes the ciphertext.

---
 rtl/rc4_encryptor.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/rc4_encryptor.sv
// rc4_encryptor: single-core RC4 writer (init, KSA, PRGA) for one key.
// Drives an external 256-entry S RAM, a plaintext read port and a ciphertext write port.
module rc4_encryptor #(
    parameter int RAM_WIDTH          = 8,
    parameter int RAM_LENGTH         = 8,
    parameter int KEY_LENGTH         = 3,
    parameter int MESSAGE_LENGTH     = 32,
    parameter int MESSAGE_LOG_LENGTH = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [KEY_LENGTH*8-1:0]       key,
    output logic                          busy,
    output logic                          done,
    output logic [RAM_LENGTH-1:0]         sAddr,
    output logic [RAM_WIDTH-1:0]          sIn,
    output logic                          sWren,
    input  logic [RAM_WIDTH-1:0]          sOut,
    output logic [MESSAGE_LOG_LENGTH-1:0] pAddr,
    input  logic [RAM_WIDTH-1:0]          pOut,
    output logic [MESSAGE_LOG_LENGTH-1:0] cAddr,
    output logic [RAM_WIDTH-1:0]          cIn,
    output logic                          cWren
);

    localparam int KW = KEY_LENGTH * 8;
    localparam logic [RAM_LENGTH-1:0] I_LAST = '1;
    localparam logic [MESSAGE_LOG_LENGTH-1:0] K_LAST =
        MESSAGE_LOG_LENGTH'(MESSAGE_LENGTH - 1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT,
        ST_RD_I,
        ST_LD_I,
        ST_RD_J,
        ST_LD_J,
        ST_WR_I,
        ST_WR_J,
        ST_RD_F,
        ST_WR_C,
        ST_FINISH
    } state_t;

    state_t r_state;
    state_t w_next;

    logic                          r_prga;
    logic [RAM_LENGTH-1:0]         r_i;
    logic [RAM_LENGTH-1:0]         r_j;
    logic [MESSAGE_LOG_LENGTH-1:0] r_k;
    logic [KW-1:0]                 r_key;
    logic [RAM_WIDTH-1:0]          r_si;
    logic [RAM_WIDTH-1:0]          r_sj;

    logic [RAM_LENGTH-1:0] w_iaddr;
    logic [RAM_LENGTH-1:0] w_sout_idx;
    logic [RAM_LENGTH-1:0] w_kbyte;
    logic [RAM_LENGTH-1:0] w_faddr;

    // PRGA pre-increments i; KSA uses i as-is and advances it after the swap
    assign w_iaddr    = r_prga ? r_i + 1'b1 : r_i;
    assign w_sout_idx = RAM_LENGTH'(sOut);
    assign w_kbyte    = RAM_LENGTH'(r_key[KW-1 -: 8]);
    assign w_faddr    = RAM_LENGTH'(r_si) + RAM_LENGTH'(r_sj);

    assign busy = (r_state != ST_IDLE) && (r_state != ST_FINISH);
    assign done = (r_state == ST_FINISH);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        sAddr  = '0;
        sIn    = '0;
        sWren  = 1'b0;
        pAddr  = r_k;
        cAddr  = r_k;
        cIn    = '0;
        cWren  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = ST_INIT;
                end
            end
            ST_INIT: begin
                sAddr = r_i;
                sIn   = RAM_WIDTH'(r_i);
                sWren = 1'b1;
                if (r_i == I_LAST) begin
                    w_next = ST_RD_I;
                end
            end
            ST_RD_I: begin
                sAddr  = w_iaddr;
                w_next = ST_LD_I;
            end
            ST_LD_I: begin
                w_next = ST_RD_J;
            end
            ST_RD_J: begin
                sAddr  = r_j;
                w_next = ST_LD_J;
            end
            ST_LD_J: begin
                w_next = ST_WR_I;
            end
            ST_WR_I: begin
                sAddr  = r_i;
                sIn    = r_sj;
                sWren  = 1'b1;
                w_next = ST_WR_J;
            end
            ST_WR_J: begin
                sAddr  = r_j;
                sIn    = r_si;
                sWren  = 1'b1;
                w_next = r_prga ? ST_RD_F : ST_RD_I;
            end
            ST_RD_F: begin
                sAddr  = w_faddr;
                pAddr  = r_k;
                w_next = ST_WR_C;
            end
            ST_WR_C: begin
                cAddr  = r_k;
                cIn    = sOut ^ pOut;
                cWren  = 1'b1;
                w_next = (r_k == K_LAST) ? ST_FINISH : ST_RD_I;
            end
            ST_FINISH: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_prga <= 1'b0;
            r_i    <= '0;
            r_j    <= '0;
            r_k    <= '0;
            r_key  <= '0;
            r_si   <= '0;
            r_sj   <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_key  <= key;
                        r_prga <= 1'b0;
                        r_i    <= '0;
                        r_j    <= '0;
                        r_k    <= '0;
                    end
                end
                ST_INIT: begin
                    r_i <= r_i + 1'b1;
                end
                ST_RD_I: begin
                    r_i <= w_iaddr;
                end
                ST_LD_I: begin
                    r_si <= sOut;
                    if (r_prga) begin
                        r_j <= r_j + w_sout_idx;
                    end else begin
                        r_j <= r_j + w_sout_idx + w_kbyte;
                    end
                end
                ST_LD_J: begin
                    r_sj <= sOut;
                end
                ST_WR_J: begin
                    if (!r_prga) begin
                        r_i   <= r_i + 1'b1;
                        // rotation makes the key index wrap at KEY_LENGTH
                        r_key <= (r_key << 8) | (r_key >> (KW - 8));
                        if (r_i == I_LAST) begin
                            r_prga <= 1'b1;
                            r_j    <= '0;
                        end
                    end
                end
                ST_WR_C: begin
                    r_k <= r_k + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
